// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-wide register port: fixed bus address, auto-incrementing pointer.
// Define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample majority filter behind each synchronizer.
module i2c_slave_regs #(
  parameter logic [6:0] SLV_ADDR  = 7'h50,
  parameter int         PTR_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_o,
  output logic                 sda_dir_o,
  output logic                 busy_o,
  output logic [PTR_WIDTH-1:0] reg_addr_o,
  output logic [7:0]           reg_wdat_o,
  output logic                 reg_wr_o,
  output logic                 reg_rd_o,
  input  logic [7:0]           reg_rdat_i,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  state_t               state;
  logic [1:0]           scl_sync, sda_sync;
  logic                 scl_f, sda_f, scl_q, sda_q;
  logic                 start, stop, rise, fall;
  logic [3:0]           bit_cnt;
  logic [7:0]           shift;
  logic [PTR_WIDTH-1:0] ptr;
  logic                 rw;
  logic                 sda_dir, busy, reg_wr;
  logic [7:0]           wdat;

  // Synchronizers reset to the idle-bus level so reset release never looks like an event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign start = scl_f & scl_q & sda_q & ~sda_f;
  assign stop  = scl_f & scl_q & ~sda_q & sda_f;
  assign rise  = scl_f & ~scl_q;
  assign fall  = ~scl_f & scl_q;

  // Read strobe is same-cycle so reg_rdat_i is captured while reg_rd_o is high.
  assign reg_rd_o = fall & ((state == ADDR_ACK && rw) || state == RDATA_ACK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_dir <= 1'b0;
      busy    <= 1'b0;
      reg_wr  <= 1'b0;
      wdat    <= 8'h00;
    end else begin
      reg_wr <= 1'b0;
      if (start) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        busy    <= 1'b1;
        sda_dir <= 1'b0;
      end else if (stop) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_dir <= 1'b0;
      end else if (rise) begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
              if (state == WDATA && bit_cnt == 4'd7) begin
                reg_wr <= 1'b1;
                wdat   <= {shift[6:0], sda_f};
              end
            end
          end
          RDATA:     if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
          RDATA_ACK: if (sda_f) state <= IGNORE;
          default: ;
        endcase
      end else if (fall) begin
        case (state)
          ADDR: begin
            if (bit_cnt == 4'd8) begin
              if (shift[7:1] == SLV_ADDR) begin
                sda_dir <= 1'b1;
                rw      <= shift[0];
                state   <= ADDR_ACK;
              end else begin
                sda_dir <= 1'b0;
                state   <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            bit_cnt <= 4'd0;
            if (rw) begin
              state   <= RDATA;
              shift   <= reg_rdat_i;
              sda_dir <= ~reg_rdat_i[7];
            end else begin
              state   <= PTR;
              sda_dir <= 1'b0;
            end
          end
          PTR: begin
            if (bit_cnt == 4'd8) begin
              ptr     <= shift;
              sda_dir <= 1'b1;
              state   <= PTR_ACK;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (state == WDATA_ACK) ptr <= ptr + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
            sda_dir <= 1'b0;
            bit_cnt <= 4'd0;
            state   <= WDATA;
          end
          WDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_dir <= 1'b1;
              state   <= WDATA_ACK;
            end
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_dir <= 1'b0;
              ptr     <= ptr + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
              state   <= RDATA_ACK;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              sda_dir <= ~shift[6];
            end
          end
          RDATA_ACK: begin
            // Reaching this fall means the master ACKed; a NACK already left for IGNORE.
            state   <= RDATA;
            bit_cnt <= 4'd0;
            shift   <= reg_rdat_i;
            sda_dir <= ~reg_rdat_i[7];
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_o      = 1'b0;
  assign sda_dir_o  = sda_dir;
  assign busy_o     = busy;
  assign reg_addr_o = ptr;
  assign reg_wdat_o = wdat;
  assign reg_wr_o   = reg_wr;
  assign state_o    = state;

endmodule
